body_collision_scanner: RTL and testbench
=========================================

// Module: body_collision_scanner
// PURPOSE
//  Parametrised successor to the fixed planet/asteroid hit logic of the SAT game top level.
//  Holds a writable table of N circular bodies: planets, asteroids or goal.
//  Once per frame (rising edge of VGA_VS), sequentially tests the vessel circle against every
//  valid body and reports crash, first-hit index, hit count and win.
//  Sits between vessel/orbitmachine position sources and color_mapper/game-state logic.
// PARAMETERS
//  N_BODIES  32                  number of table entries (>=2)
//  COORD_W   10                  unsigned X/Y coordinate width, in pixels
//  RAD_W     6                   unsigned radius width, in pixels
//  IDX_W     $clog2(N_BODIES)    table index width
// PORTS
//  Clk         in   1        system clock (CLOCK_50); the only clock
//  Reset_n     in   1        asynchronous, active-low reset
//  frame_vs    in   1        VGA_VS level; synchronised internally (2 flops), rising edge starts a scan
//  vessel_x    in   COORD_W  vessel centre X
//  vessel_y    in   COORD_W  vessel centre Y
//  vessel_s    in   RAD_W    vessel radius
//  wr_en       in   1        table write strobe
//  wr_idx      in   IDX_W    entry to write
//  wr_x        in   COORD_W  body centre X
//  wr_y        in   COORD_W  body centre Y
//  wr_s        in   RAD_W    body radius
//  wr_kind     in   2        0=planet, 1=asteroid, 2=goal, 3=disabled (valid cleared)
//  busy        out  1        scan in progress
//  done        out  1        1-cycle pulse; results updated this cycle
//  crash       out  1        a planet/asteroid overlapped the vessel in the last scan
//  crash_idx   out  IDX_W    lowest index that caused crash; 0 if none
//  hit_count   out  IDX_W+1  number of hazard overlaps in the last scan
//  win         out  1        a goal body overlapped the vessel in the last scan
//  overrun     out  1        sticky: frame edge arrived while busy; cleared only by reset
// BEHAVIOUR
//  Reset (async, Reset_n=0):
//   - All outputs 0.
//   - FSM to IDLE; all table entries invalid; synchroniser flops 0.
//  FSM: IDLE -> LOAD -> SCAN -> DRAIN -> REPORT -> IDLE.
//   - IDLE: on synchronised rising edge of frame_vs, go to LOAD.
//   - LOAD (1 cycle):
//     - Latch vessel_x/y/s into shadow regs; inputs are ignored for the rest of the scan.
//     - Clear the accumulators; set rd_idx=0; assert busy.
//   - SCAN: one entry per cycle, rd_idx 0..N_BODIES-1.
//     - Stage 1 registers dx=|bx-vx|, dy=|by-vy|, rsum=bs+vs, kind, valid, idx.
//     - Stage 2 compares dx*dx+dy*dy < rsum*rsum. Strict: touching is not a hit.
//     - After rd_idx=N_BODIES-1, go to DRAIN.
//   - DRAIN: 2 cycles to empty the pipeline.
//   - REPORT (1 cycle):
//     - Copy accumulators to crash/crash_idx/hit_count/win; pulse done.
//     - Deassert busy on the next cycle; return to IDLE.
//  Latency: edge detected -> done = N_BODIES+4 cycles.
//   - Outputs hold their values between REPORTs.
//  Arithmetic and width rules:
//   - dx, dy: COORD_W bits. Squares: 2*COORD_W bits. Sum: 2*COORD_W+1 bits.
//   - rsum: RAD_W+1 bits. rsum^2: 2*RAD_W+2 bits, zero-extended for the compare.
//   - No truncation anywhere.
//  Hit classification (only entries with valid=1 count):
//   - kind 0/1 hit: hit_count increments.
//   - First hazard hit: set crash and record its idx. Later hits never overwrite crash_idx.
//   - kind 2 hit: sets win only.
//   - crash and win in the same scan: both reported.
//  Table writes:
//   - Accepted in any state.
//   - A write in the same cycle stage 1 reads that idx: the scan uses the OLD value (read-before-write).
//   - wr_kind=3 clears valid.
//  Frame edge while not in IDLE: ignored (no restart); overrun set.
//  Reset mid-scan: immediate return to reset values; the table is cleared.
// TESTING
//  1. Reset, no writes, frame edge.
//     -> done at cycle N_BODIES+4; crash=0, win=0, hit_count=0.
//  2. Entry 5 planet (350,250,s10); vessel (355,250,s4).
//     -> crash=1, crash_idx=5, hit_count=1.
//  3. Entry 3 at (100,100,s6); vessel (110,100,s4). dist^2=100, rsum^2=100.
//     -> no hit (strict <).
//  4. Asteroids at idx 2 and 9 overlapping; goal at idx 20 overlapping.
//     -> crash_idx=2, hit_count=2, win=1.
//  5. Second frame edge 10 cycles into a scan.
//     -> scan unaffected; overrun=1 and stays 1.
//     Write idx 4 to disabled coincident with its read -> old entry still counted.
//  6. Reset_n low mid-SCAN.
//     -> busy=0, all outputs 0 immediately; next scan after reset reports no hits.
//     Coordinates (1023,0) vs (0,1023) -> no overflow, no hit.

Source files
------------

// File: rtl/body_collision_scanner.sv
// Per-frame circle-overlap scanner: tests the vessel against a writable table of bodies
// through a two-stage pipeline and reports crash / first hazard index / hazard count / win.
module body_collision_scanner #(
    parameter int N_BODIES = 32,
    parameter int COORD_W  = 10,
    parameter int RAD_W    = 6,
    parameter int IDX_W    = $clog2(N_BODIES)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_vs,
    input  logic [COORD_W-1:0] vessel_x,
    input  logic [COORD_W-1:0] vessel_y,
    input  logic [RAD_W-1:0]   vessel_s,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [RAD_W-1:0]   wr_s,
    input  logic [1:0]         wr_kind,
    output logic               busy,
    output logic               done,
    output logic               crash,
    output logic [IDX_W-1:0]   crash_idx,
    output logic [IDX_W:0]     hit_count,
    output logic               win,
    output logic               overrun
);

    localparam int SQ_W   = 2 * COORD_W;
    localparam int DIST_W = 2 * COORD_W + 1;
    localparam int RS_W   = RAD_W + 1;
    localparam int R2_W   = 2 * RAD_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BODIES - 1);

    typedef struct packed {
        logic               valid;
        logic [1:0]         kind;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [RAD_W-1:0]   s;
    } body_t;

    typedef enum logic [2:0] {IDLE, LOAD, SCAN, DRAIN, REPORT} state_t;

    state_t state, state_nx;

    body_t              table_q [N_BODIES];
    logic               vs_meta, vs_sync, vs_prev, frame_edge;
    logic [COORD_W-1:0] sh_x, sh_y;
    logic [RAD_W-1:0]   sh_s;
    logic [IDX_W-1:0]   rd_idx;
    logic               drain_cnt;
    logic               load, scan_rd, last_drain;

    // Two-flop synchroniser plus a history flop for rising-edge detection
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_meta <= frame_vs;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end
    assign frame_edge = vs_sync & ~vs_prev;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (frame_edge) state_nx = LOAD;
            LOAD:    state_nx = SCAN;
            SCAN:    if (rd_idx == LAST_IDX) state_nx = DRAIN;
            DRAIN:   if (drain_cnt) state_nx = REPORT;
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        load       = (state == LOAD);
        scan_rd    = (state == SCAN);
        last_drain = (state == DRAIN) && drain_cnt;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_BODIES; i++) table_q[i] <= '0;
        end else if (wr_en && ({1'b0, wr_idx} < (IDX_W + 1)'(N_BODIES))) begin
            table_q[wr_idx] <= '{valid: (wr_kind != 2'd3), kind: wr_kind,
                                 x: wr_x, y: wr_y, s: wr_s};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_x      <= '0;
            sh_y      <= '0;
            sh_s      <= '0;
            rd_idx    <= '0;
            drain_cnt <= 1'b0;
        end else begin
            if (load) begin
                sh_x <= vessel_x;
                sh_y <= vessel_y;
                sh_s <= vessel_s;
            end
            if (load)         rd_idx <= '0;
            else if (scan_rd) rd_idx <= rd_idx + 1'b1;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // Stage 1: absolute deltas and radius sum; the table read sees pre-write contents
    body_t              rd_body;
    logic [COORD_W-1:0] dx_c, dy_c;
    logic               s1_vld, s1_valid;
    logic [1:0]         s1_kind;
    logic [IDX_W-1:0]   s1_idx;
    logic [COORD_W-1:0] s1_dx, s1_dy;
    logic [RS_W-1:0]    s1_rsum;

    always_comb begin
        rd_body = table_q[rd_idx];
        dx_c    = (rd_body.x >= sh_x) ? (rd_body.x - sh_x) : (sh_x - rd_body.x);
        dy_c    = (rd_body.y >= sh_y) ? (rd_body.y - sh_y) : (sh_y - rd_body.y);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_vld   <= 1'b0;
            s1_valid <= 1'b0;
            s1_kind  <= '0;
            s1_idx   <= '0;
            s1_dx    <= '0;
            s1_dy    <= '0;
            s1_rsum  <= '0;
        end else begin
            s1_vld   <= scan_rd;
            s1_valid <= rd_body.valid;
            s1_kind  <= rd_body.kind;
            s1_idx   <= rd_idx;
            s1_dx    <= dx_c;
            s1_dy    <= dy_c;
            s1_rsum  <= {1'b0, rd_body.s} + {1'b0, sh_s};
        end
    end

    // Stage 2: full-width squared distance vs squared radius sum, strict less-than
    logic [SQ_W-1:0]   dx2, dy2;
    logic [DIST_W-1:0] dist2;
    logic [R2_W-1:0]   r2;
    logic              hit, haz_hit, goal_hit;

    always_comb begin
        dx2      = {{COORD_W{1'b0}}, s1_dx} * {{COORD_W{1'b0}}, s1_dx};
        dy2      = {{COORD_W{1'b0}}, s1_dy} * {{COORD_W{1'b0}}, s1_dy};
        dist2    = {1'b0, dx2} + {1'b0, dy2};
        r2       = {{(R2_W-RS_W){1'b0}}, s1_rsum} * {{(R2_W-RS_W){1'b0}}, s1_rsum};
        hit      = s1_vld && s1_valid && (dist2 < DIST_W'(r2));
        haz_hit  = hit && !s1_kind[1];
        goal_hit = hit && (s1_kind == 2'd2);
    end

    logic             acc_crash, acc_win;
    logic [IDX_W-1:0] acc_idx;
    logic [IDX_W:0]   acc_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc_crash <= 1'b0;
            acc_win   <= 1'b0;
            acc_idx   <= '0;
            acc_cnt   <= '0;
        end else if (load) begin
            acc_crash <= 1'b0;
            acc_win   <= 1'b0;
            acc_idx   <= '0;
            acc_cnt   <= '0;
        end else begin
            if (haz_hit) begin
                acc_cnt <= acc_cnt + 1'b1;
                if (!acc_crash) begin
                    acc_crash <= 1'b1;
                    acc_idx   <= s1_idx;
                end
            end
            if (goal_hit) acc_win <= 1'b1;
        end
    end

    // Results land on the edge entering REPORT so they are valid while done is high
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            done      <= 1'b0;
            crash     <= 1'b0;
            crash_idx <= '0;
            hit_count <= '0;
            win       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= last_drain;
            if (last_drain) begin
                crash     <= acc_crash;
                crash_idx <= acc_idx;
                hit_count <= acc_cnt;
                win       <= acc_win;
            end
            if (frame_edge && (state != IDLE)) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_body_collision_scanner.sv
// Directed bench for body_collision_scanner: latency, strict overlap, classification,
// overrun, read-before-write and mid-scan reset.
module tb_body_collision_scanner;

    localparam int N   = 32;
    localparam int LAT = N + 6;  // negedges from frame_vs rise to done (2 sync + N+4)

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_vs = 1'b0;
    logic [9:0] vessel_x = '0, vessel_y = '0;
    logic [5:0] vessel_s = '0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_idx = '0;
    logic [9:0] wr_x = '0, wr_y = '0;
    logic [5:0] wr_s = '0;
    logic [1:0] wr_kind = '0;
    logic       busy, done, crash, win, overrun;
    logic [4:0] crash_idx;
    logic [5:0] hit_count;

    int checks = 0;
    int passes = 0;

    body_collision_scanner #(.N_BODIES(N), .COORD_W(10), .RAD_W(6)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_vs(frame_vs),
        .vessel_x(vessel_x), .vessel_y(vessel_y), .vessel_s(vessel_s),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_s(wr_s),
        .wr_kind(wr_kind), .busy(busy), .done(done), .crash(crash),
        .crash_idx(crash_idx), .hit_count(hit_count), .win(win), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    task automatic do_reset();
        Reset_n  = 1'b0;
        frame_vs = 1'b0;
        wr_en    = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic write_body(input int idx, input int x, input int y, input int s, input int kind);
        @(negedge Clk);
        wr_en   = 1'b1;
        wr_idx  = 5'(idx);
        wr_x    = 10'(x);
        wr_y    = 10'(y);
        wr_s    = 6'(s);
        wr_kind = 2'(kind);
        @(negedge Clk);
        wr_en = 1'b0;
    endtask

    task automatic set_vessel(input int x, input int y, input int s);
        vessel_x = 10'(x);
        vessel_y = 10'(y);
        vessel_s = 6'(s);
    endtask

    // Raises frame_vs, optionally a second edge and a disabling write, returns negedges to done
    task automatic run_frame(input int edge2_at, input int dis_at, input int dis_idx, output int cyc);
        @(negedge Clk);
        frame_vs = 1'b1;
        cyc = 0;
        while (1) begin
            @(negedge Clk);
            cyc++;
            if (cyc == 4) frame_vs = 1'b0;
            if (edge2_at != 0 && cyc == edge2_at) frame_vs = 1'b1;
            if (edge2_at != 0 && cyc == edge2_at + 4) frame_vs = 1'b0;
            if (dis_at != 0 && cyc == dis_at) begin
                wr_en = 1'b1; wr_idx = 5'(dis_idx); wr_kind = 2'd3;
            end
            if (dis_at != 0 && cyc == dis_at + 1) wr_en = 1'b0;
            if (done === 1'b1) break;
            if (cyc >= 200) begin
                $display("FAIL run_frame_timeout: no done after %0d cycles", cyc);
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({busy, done, crash, win, overrun} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {busy, done, crash, win, overrun});
        else passes++;
        checks++; if ({crash_idx, hit_count} !== 11'd0)
            $display("FAIL reset_counts: got idx %0d cnt %0d want 0 0", crash_idx, hit_count);
        else passes++;
    endtask

    task automatic test_empty_scan();
        int cyc;
        set_vessel(100, 100, 10);
        run_frame(0, 0, 0, cyc);
        checks++; if (cyc !== LAT) $display("FAIL empty_latency: got %0d want %0d", cyc, LAT);
        else passes++;
        checks++; if ({crash, win, hit_count} !== 8'd0)
            $display("FAIL empty_result: got crash %0d win %0d cnt %0d want 0 0 0", crash, win, hit_count);
        else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL empty_busy_at_done: got %0d want 1", busy);
        else passes++;
        @(negedge Clk);
        checks++; if ({done, busy} !== 2'b00) $display("FAIL done_pulse: got done %0d busy %0d want 0 0", done, busy);
        else passes++;
    endtask

    task automatic test_planet_hit();
        int cyc;
        do_reset();
        write_body(5, 350, 250, 10, 0);
        set_vessel(355, 250, 4);
        run_frame(0, 0, 0, cyc);
        checks++; if (cyc !== LAT) $display("FAIL planet_latency: got %0d want %0d", cyc, LAT);
        else passes++;
        checks++; if (crash !== 1'b1 || crash_idx !== 5'd5)
            $display("FAIL planet_crash: got crash %0d idx %0d want 1 5", crash, crash_idx);
        else passes++;
        checks++; if (hit_count !== 6'd1 || win !== 1'b0)
            $display("FAIL planet_count: got cnt %0d win %0d want 1 0", hit_count, win);
        else passes++;
        // results must hold between reports
        repeat (5) @(negedge Clk);
        checks++; if (crash !== 1'b1 || hit_count !== 6'd1)
            $display("FAIL planet_hold: got crash %0d cnt %0d want 1 1", crash, hit_count);
        else passes++;
    endtask

    task automatic test_touching();
        int cyc;
        do_reset();
        write_body(3, 100, 100, 6, 0);
        set_vessel(110, 100, 4);
        run_frame(0, 0, 0, cyc);
        checks++; if (cyc !== LAT) $display("FAIL touch_latency: got %0d want %0d", cyc, LAT);
        else passes++;
        checks++; if (crash !== 1'b0 || hit_count !== 6'd0)
            $display("FAIL touch_nohit: got crash %0d cnt %0d want 0 0", crash, hit_count);
        else passes++;
        // one pixel closer overlaps
        set_vessel(109, 100, 4);
        run_frame(0, 0, 0, cyc);
        checks++; if (crash !== 1'b1 || crash_idx !== 5'd3)
            $display("FAIL touch_closer: got crash %0d idx %0d want 1 3", crash, crash_idx);
        else passes++;
    endtask

    task automatic test_multi();
        int cyc;
        do_reset();
        write_body(9, 305, 300, 5, 1);
        write_body(2, 300, 300, 5, 1);
        write_body(20, 300, 310, 8, 2);
        write_body(15, 500, 100, 5, 0);
        set_vessel(300, 300, 5);
        run_frame(0, 0, 0, cyc);
        checks++; if (cyc !== LAT) $display("FAIL multi_latency: got %0d want %0d", cyc, LAT);
        else passes++;
        checks++; if (crash !== 1'b1 || crash_idx !== 5'd2)
            $display("FAIL multi_crash_idx: got crash %0d idx %0d want 1 2", crash, crash_idx);
        else passes++;
        checks++; if (hit_count !== 6'd2) $display("FAIL multi_count: got %0d want 2", hit_count);
        else passes++;
        checks++; if (win !== 1'b1) $display("FAIL multi_win: got %0d want 1", win);
        else passes++;
        // disable both asteroids: only the goal remains
        write_body(2, 0, 0, 0, 3);
        write_body(9, 0, 0, 0, 3);
        run_frame(0, 0, 0, cyc);
        checks++; if ({crash, win, hit_count} !== {1'b0, 1'b1, 6'd0})
            $display("FAIL goal_only: got crash %0d win %0d cnt %0d want 0 1 0", crash, win, hit_count);
        else passes++;
    endtask

    task automatic test_overrun_rbw();
        int cyc;
        do_reset();
        write_body(4, 200, 200, 10, 0);
        set_vessel(200, 205, 4);
        checks++; if (overrun !== 1'b0) $display("FAIL overrun_pre: got %0d want 0", overrun);
        else passes++;
        // rd_idx=4 is read during the cycle before negedge 9 counted from the frame rise
        run_frame(10, 8, 4, cyc);
        checks++; if (cyc !== LAT) $display("FAIL overrun_latency: got %0d want %0d", cyc, LAT);
        else passes++;
        checks++; if (crash !== 1'b1 || crash_idx !== 5'd4 || hit_count !== 6'd1)
            $display("FAIL rbw_old_entry: got crash %0d idx %0d cnt %0d want 1 4 1", crash, crash_idx, hit_count);
        else passes++;
        checks++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %0d want 1", overrun);
        else passes++;
        repeat (6) @(negedge Clk);
        checks++; if (busy !== 1'b0) $display("FAIL overrun_no_restart: got busy %0d want 0", busy);
        else passes++;
        run_frame(0, 0, 0, cyc);
        checks++; if (crash !== 1'b0 || hit_count !== 6'd0)
            $display("FAIL rbw_now_disabled: got crash %0d cnt %0d want 0 0", crash, hit_count);
        else passes++;
        checks++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %0d want 1", overrun);
        else passes++;
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        write_body(5, 350, 250, 10, 0);
        set_vessel(355, 250, 4);
        run_frame(0, 0, 0, cyc);
        checks++; if (crash !== 1'b1) $display("FAIL midrst_precrash: got %0d want 1", crash);
        else passes++;
        @(negedge Clk);
        frame_vs = 1'b1;
        repeat (4) @(negedge Clk);
        frame_vs = 1'b0;
        repeat (11) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        checks++; if ({busy, done, crash, win, overrun} !== 5'b0)
            $display("FAIL midrst_flags: got %b want 00000", {busy, done, crash, win, overrun});
        else passes++;
        checks++; if ({crash_idx, hit_count} !== 11'd0)
            $display("FAIL midrst_counts: got idx %0d cnt %0d want 0 0", crash_idx, hit_count);
        else passes++;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        run_frame(0, 0, 0, cyc);
        checks++; if (cyc !== LAT || crash !== 1'b0 || hit_count !== 6'd0)
            $display("FAIL midrst_table_cleared: got cyc %0d crash %0d cnt %0d want %0d 0 0", cyc, crash, hit_count, LAT);
        else passes++;
    endtask

    task automatic test_extreme_coords();
        int cyc;
        do_reset();
        write_body(0, 1023, 0, 63, 0);
        set_vessel(0, 1023, 63);
        run_frame(0, 0, 0, cyc);
        checks++; if ({crash, win, hit_count} !== 8'd0)
            $display("FAIL extreme_nohit: got crash %0d win %0d cnt %0d want 0 0 0", crash, win, hit_count);
        else passes++;
        // dx=63, rsum=64: 3969 < 4096 overlaps
        write_body(1, 63, 1023, 63, 1);
        set_vessel(0, 1023, 1);
        run_frame(0, 0, 0, cyc);
        checks++; if (crash !== 1'b1 || crash_idx !== 5'd1 || hit_count !== 6'd1)
            $display("FAIL extreme_edge_hit: got crash %0d idx %0d cnt %0d want 1 1 1", crash, crash_idx, hit_count);
        else passes++;
        write_body(31, 600, 600, 3, 0);
        set_vessel(600, 602, 1);
        run_frame(0, 0, 0, cyc);
        checks++; if (crash !== 1'b1 || crash_idx !== 5'd31)
            $display("FAIL last_entry: got crash %0d idx %0d want 1 31", crash, crash_idx);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_empty_scan();
        test_planet_hit();
        test_touching();
        test_multi();
        test_overrun_rbw();
        test_reset_mid_scan();
        test_extreme_coords();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
